// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   state_e      : loader FSM states
//   HdrBytes     : bytes in the word-count header (also bytes per word)
//   DefaultDepth : default instruction-memory depth in 32-bit words
//   DefaultAw    : default word-address width of the inst_mem port
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  localparam int unsigned HdrBytes     = 4;
  localparam int unsigned DefaultDepth = 25501;
  localparam int unsigned DefaultAw    = 30;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
//   valid : source holds a byte on data
//   data  : stream byte
//   ready : sink accepts data this cycle
// master = byte source (UART RX / driver), slave = loader.
interface imem_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler shared by the header and data phases.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : drop any partial word and restart at byte 0
//   accept_i      : byte_i is consumed this cycle
//   byte_i        : incoming byte
//   word_o        : word formed by the assembly register plus byte_i
//   word_done_o   : accept_i on the last byte of a word; word_o is complete
module imem_loader_byte_to_word
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;

  always_comb begin
    // Shift right so the first byte ends up in bits [7:0] after four bytes.
    word_o      = {byte_i, asm_q[31:8]};
    word_done_o = accept_i && (cnt_q == 2'(HdrBytes - 1));
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    if (clear_i) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (accept_i) begin
      cnt_d = cnt_q + 2'd1;  // wraps to 0 after the last byte
      asm_d = word_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Reads a 32-bit little-endian word
// count, then that many words, writing them to word addresses 0.. and
// holding the core in reset until the image is complete.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   start_i       : begin a load (honoured in idle, done or error)
//   in_if         : byte stream (slave side)
//   mem_we_o      : one-cycle write strobe per word
//   mem_waddr_o   : word address
//   mem_wdata_o   : instruction word
//   busy_o        : load in progress
//   done_o        : last load completed
//   err_o         : header count exceeded Depth
//   core_rst_no   : active-low core reset, released only when done
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth,
  parameter int unsigned Aw    = DefaultAw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  imem_loader_if.slave  in_if,
  output logic          mem_we_o,
  output logic [Aw-1:0] mem_waddr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          core_rst_no
);

  state_e        state_q;
  logic          ready_q, we_q, busy_q, done_q, err_q, core_rst_n_q;
  logic [Aw-1:0] waddr_q, index_q;
  logic [31:0]   wdata_q, count_q;

  logic          accept, start_ok, word_done;
  logic [31:0]   word;
  logic [Aw-1:0] idx_inc;

  assign in_if.ready = ready_q;
  assign accept      = in_if.valid && ready_q;
  assign start_ok    = start_i && (state_q inside {StIdle, StDone, StErr});
  assign idx_inc     = index_q + 1'b1;

  assign mem_we_o    = we_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign core_rst_no = core_rst_n_q;

  imem_loader_byte_to_word u_b2w (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (start_ok),
    .accept_i    (accept),
    .byte_i      (in_if.data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  // Outputs are registered alongside the state, so each is set on the
  // transition into the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      index_q      <= '0;
      count_q      <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start_i) begin
            state_q      <= StHdr;
            ready_q      <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
          end
        end
        StHdr: begin
          if (word_done) begin
            count_q <= word;
            index_q <= '0;
            if (word == 32'd0) begin
              state_q      <= StDone;
              ready_q      <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else if (word > Depth) begin
              state_q <= StErr;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (word_done) begin
            state_q <= StWrite;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            waddr_q <= index_q;
            wdata_q <= word;
          end
        end
        StWrite: begin
          index_q <= idx_inc;
          if (32'(idx_inc) == count_q) begin
            state_q      <= StDone;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            core_rst_n_q <= 1'b1;
          end else begin
            state_q <= StData;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader with a small Depth so that a
// full-depth image fits in a short run.
module tb_imem_loader;

  localparam int unsigned Depth = 6;
  localparam int unsigned Aw    = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_we;
  logic [Aw-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          busy, done, err, core_rst_n;

  imem_loader_if ifc ();

  always #5 clk = ~clk;

  imem_loader #(
    .Depth (Depth),
    .Aw    (Aw)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .in_if       (ifc),
    .mem_we_o    (mem_we),
    .mem_waddr_o (mem_waddr),
    .mem_wdata_o (mem_wdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .core_rst_no (core_rst_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: record every strobe, and the source must be stalled then.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(32'(mem_waddr));
      wr_data.push_back(mem_wdata);
      check("in_ready_low_in_write", 32'(ifc.ready), 32'd0);
    end
  end

  // All tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int n;
    if (gappy) begin
      ifc.valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    ifc.valid = 1'b1;
    ifc.data  = b;
    n = 0;
    while (ifc.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_accept_timeout", 32'(ifc.ready), 32'd1);
    @(negedge clk);
    ifc.valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gappy);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gappy);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("end_timeout", 32'(done | err), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(ifc.ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  typedef struct {
    string           name;
    logic [31:0]     count;
    int              nwords;
    logic [3:0][31:0] w;
    bit              gappy;
    bit              exp_done;
    bit              exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached without finishing");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{name: "three_words", count: 32'd3, nwords: 3,
                w: {32'h0, 32'h0000006F, 32'h00100093, 32'h00000013},
                gappy: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{name: "three_words_gappy", count: 32'd3, nwords: 3,
                w: {32'h0, 32'h0000006F, 32'h00100093, 32'h00000013},
                gappy: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{name: "zero_count", count: 32'd0, nwords: 0,
                w: '0, gappy: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{name: "depth_plus_one", count: 32'(Depth + 1), nwords: 0,
                w: '0, gappy: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[4] = '{name: "one_word_after_err", count: 32'd1, nwords: 1,
                w: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                gappy: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[5] = '{name: "two_words_gappy", count: 32'd2, nwords: 2,
                w: {32'h0, 32'h0, 32'hA5A50F0F, 32'h12345678},
                gappy: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

    ifc.valid = 1'b0;
    ifc.data  = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(ifc.ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Table-driven loads.
    for (int v = 0; v < 6; v++) begin
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      check({vecs[v].name, "_busy_after_start"}, 32'(busy), 32'd1);
      check({vecs[v].name, "_err_cleared"}, 32'(err), 32'd0);
      check({vecs[v].name, "_core_rst_held"}, 32'(core_rst_n), 32'd0);
      send_word(vecs[v].count, vecs[v].gappy);
      if (vecs[v].count == 32'd0) check({vecs[v].name, "_done_next_cycle"}, 32'(done), 32'd1);
      if (vecs[v].exp_err) check({vecs[v].name, "_err_next_cycle"}, 32'(err), 32'd1);
      for (int i = 0; i < vecs[v].nwords; i++) send_word(vecs[v].w[i], vecs[v].gappy);
      wait_end();
      check({vecs[v].name, "_done"}, 32'(done), 32'(vecs[v].exp_done));
      check({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].exp_err));
      check({vecs[v].name, "_core_rst_n"}, 32'(core_rst_n), 32'(vecs[v].exp_done));
      check({vecs[v].name, "_busy"}, 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      check({vecs[v].name, "_write_count"}, 32'(wr_addr.size()),
            vecs[v].exp_done ? 32'(vecs[v].nwords) : 32'd0);
      for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
        check({vecs[v].name, "_waddr"}, wr_addr[i], 32'(i));
        check({vecs[v].name, "_wdata"}, wr_data[i], vecs[v].w[i]);
      end
    end

    // Reset after two bytes of the first data word: partial word dropped.
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midload_reset");
    repeat (3) @(negedge clk);
    check("midload_no_write", 32'(wr_addr.size()), 32'd0);
    check("midload_idle_ready", 32'(ifc.ready), 32'd0);
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    wait_end();
    check("reload_done", 32'(done), 32'd1);
    check("reload_write_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check("reload_waddr", wr_addr[0], 32'd0);
      check("reload_wdata", wr_data[0], 32'hCAFEF00D);
    end

    // count == Depth with a start pulse in the middle of the data phase.
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_word(32'(Depth), 1'b0);
    for (int i = 0; i < Depth; i++) begin
      if (i == 2) begin
        pulse_start();
        check("start_ignored_busy", 32'(busy), 32'd1);
        check("start_ignored_ready", 32'(ifc.ready), 32'd1);
      end
      send_word(32'h1000_0000 + 32'(i), 1'b0);
    end
    check("full_last_we", 32'(mem_we), 32'd1);
    check("full_last_waddr", 32'(mem_waddr), 32'(Depth - 1));
    @(negedge clk);
    check("full_done", 32'(done), 32'd1);
    check("full_we_off", 32'(mem_we), 32'd0);
    check("full_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    check("full_write_count", 32'(wr_addr.size()), 32'(Depth));
    for (int i = 0; i < wr_addr.size() && i < Depth; i++) begin
      check("full_waddr", wr_addr[i], 32'(i));
      check("full_wdata", wr_data[i], 32'h1000_0000 + 32'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
